piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 82 ++++++++
 tb/tb_piso_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load port and a bit-rate strobe.
// Back-to-back words reload on the final-bit edge, so the serial stream has no gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    cnt;
  logic             shifting;
  logic             at_last;
  logic             out_bit;
  logic             xfer;

  assign shifting = (state == SHIFT);
  assign at_last  = shifting && (cnt == LAST);

  // Ready is combinational on the final bit so the next word lands on the same edge.
  assign din_ready = !rst && (!shifting || (at_last && shift_en));
  assign xfer      = din_valid && din_ready;

  always_comb begin
    sreg_next = sreg;
    out_bit   = 1'b1;
    if (MSB_FIRST != 0) begin
      sreg_next = {sreg[WIDTH-2:0], 1'b0};
      out_bit   = sreg[WIDTH-1];
    end else begin
      sreg_next = {1'b0, sreg[WIDTH-1:1]};
      out_bit   = sreg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (xfer) begin
      state <= SHIFT;
      cnt   <= '0;
      sreg  <= din;
    end else if (shifting && shift_en) begin
      if (at_last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
        sreg <= sreg_next;
      end
    end
  end

  assign sout       = shifting ? out_bit : 1'b1;
  assign sout_valid = shifting;
  assign sout_first = shifting && (cnt == '0);
  assign sout_last  = at_last;
  assign busy       = shifting;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one stimulus,
// each checked every cycle against a word/bit-index model plus literal expectations.
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             shift_en;

  logic os [2];
  logic ov [2];
  logic of [2];
  logic ol [2];
  logic ob [2];
  logic ordy [2];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ordy[0]),
    .shift_en(shift_en), .sout(os[0]), .sout_valid(ov[0]), .sout_first(of[0]),
    .sout_last(ol[0]), .busy(ob[0])
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ordy[1]),
    .shift_en(shift_en), .sout(os[1]), .sout_valid(ov[1]), .sout_first(of[1]),
    .sout_last(ol[1]), .busy(ob[1])
  );

  int vecs = 0;
  int errs = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpi(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word in flight and how many of its bits have been consumed.
  bit               m_active [2];
  logic [WIDTH-1:0] m_word   [2];
  int               m_k      [2];

  function automatic logic m_ready(input int d);
    return !rst && (!m_active[d] || (m_k[d] == WIDTH-1 && shift_en));
  endfunction

  function automatic logic m_bit(input int d);
    int idx;
    idx = (d == 0) ? WIDTH-1-m_k[d] : m_k[d];
    return m_active[d] ? m_word[d][idx] : 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_active[d] = 0;
        m_k[d]      = 0;
      end else if (din_valid && m_ready(d)) begin
        m_active[d] = 1;
        m_word[d]   = din;
        m_k[d]      = 0;
      end else if (m_active[d] && shift_en) begin
        if (m_k[d] == WIDTH-1) m_active[d] = 0;
        else m_k[d]++;
      end
    end
  end

  // Receiver: bits consumed on edges where sout_valid and shift_en are both high.
  logic [31:0] rx  [2];
  int          rxn [2];

  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] === 1'b1 && shift_en) begin
          rx[d] = {rx[d][30:0], os[d]};
          rxn[d]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        cmp($sformatf("model_sout[%0d]", d),  os[d],   m_bit(d));
        cmp($sformatf("model_valid[%0d]", d), ov[d],   m_active[d]);
        cmp($sformatf("model_busy[%0d]", d),  ob[d],   m_active[d]);
        cmp($sformatf("model_first[%0d]", d), of[d],   m_active[d] && m_k[d] == 0);
        cmp($sformatf("model_last[%0d]", d),  ol[d],   m_active[d] && m_k[d] == WIDTH-1);
        cmp($sformatf("model_ready[%0d]", d), ordy[d], m_ready(d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    for (int d = 0; d < 2; d++) begin
      rx[d]  = '0;
      rxn[d] = 0;
    end
  endtask

  logic [7:0]  pat;
  logic [15:0] pat16;

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; shift_en = 1'b0;
    clear_rx();
    tick();
    chk_en = 1;
    cmp("rst_ready", ordy[0], 1'b0);
    tick();
    cmp("rst_sout", os[0], 1'b1);
    cmp("rst_valid", ov[0], 1'b0);
    cmp("rst_busy", ob[1], 1'b0);
    rst = 1'b0;
    #1;
    cmp("ready_after_rst_a", ordy[0], 1'b1);
    cmp("ready_after_rst_b", ordy[1], 1'b1);

    // Idle: shift_en must not disturb anything.
    for (int c = 0; c < 4; c++) begin
      shift_en = c[0];
      tick();
    end

    // Single word 0xA5, continuous strobe.
    clear_rx();
    pat = 8'hA5; din = pat; din_valid = 1'b1; shift_en = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cmp("a5_sout", os[0], pat[7-i]);
      cmp("a5_first", of[0], i == 0);
      cmp("a5_last", ol[0], i == 7);
      tick();
    end
    cmp("a5_idle_sout", os[0], 1'b1);
    cmp("a5_idle_valid", ov[0], 1'b0);
    cmp("a5_idle_ready", ordy[0], 1'b1);
    cmpi("a5_rx", int'(rx[0][7:0]), 'hA5);
    cmpi("a5_rxn", rxn[0], 8);

    // Back-to-back 0x3C then 0xC3 with valid held.
    clear_rx();
    pat16 = 16'h3CC3; din = 8'h3C; din_valid = 1'b1;
    tick();
    din = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) din_valid = 1'b0;
      cmp("b2b_sout", os[0], pat16[15-i]);
      cmp("b2b_valid", ov[0], 1'b1);
      cmp("b2b_ready", ordy[0], i == 7 || i == 15);
      tick();
    end
    cmpi("b2b_rx", int'(rx[0][15:0]), 'h3CC3);
    cmpi("b2b_rxn", rxn[0], 16);

    // Strobe every 4th cycle, word 0x81.
    clear_rx();
    pat = 8'h81; shift_en = 1'b0; din = pat; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      shift_en = (c % 4 == 0);
      cmp("slow_busy", ob[0], c <= 32);
      if (c <= 32) cmp("slow_sout", os[0], pat[7-(c-1)/4]);
      tick();
    end
    shift_en = 1'b1;
    cmpi("slow_rx", int'(rx[0][7:0]), 'h81);
    cmpi("slow_rxn", rxn[0], 8);

    // 0xFF offered mid-word of 0x00 must wait for the last-bit edge.
    clear_rx();
    din = 8'h00; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin din = 8'hFF; din_valid = 1'b1; end
      if (i == 8) din_valid = 1'b0;
      cmp("hold_ready", ordy[0], i == 7 || i == 15);
      cmp("hold_sout", os[0], i >= 8);
      tick();
    end
    cmpi("hold_rx", int'(rx[0][15:0]), 'h00FF);

    // Reset at bit 4 of 0xFF, then 0x01.
    clear_rx();
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("abort_sout", os[0], 1'b1);
    cmp("abort_valid", ov[0], 1'b0);
    cmp("abort_busy", ob[0], 1'b0);
    cmpi("abort_rxn", rxn[0], 4);
    clear_rx();
    din = 8'h01; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cmpi("after_abort_rx", int'(rx[0][7:0]), 'h01);
    cmpi("after_abort_rxn", rxn[0], 8);
    cmpi("lsb_first_rx", int'(rx[1][7:0]), 'h80);
    cmpi("lsb_first_rxn", rxn[1], 8);

    for (int c = 0; c < 3; c++) tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
